// File: rtl/quadrilatero_pkg.sv
// Shared widths and the RF read-port record used by the row dispatcher.
package quadrilatero_pkg;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned NUM_PORTS = 3;
  localparam int unsigned N_ROWS    = 4;
  localparam int unsigned RADDR_W   = 3;
  localparam int unsigned ROW_W     = $clog2(N_ROWS);
  localparam int unsigned SRC_W     = $clog2(WIDTH);

  typedef struct packed {
    logic               valid;
    logic [RADDR_W-1:0] reg_idx;
    logic [ROW_W-1:0]   row;
    logic [SRC_W-1:0]   src;
  } rf_port_req_t;

endpackage

// File: rtl/quadrilatero_grant_compactor.sv
// Picks the lowest NUM_PORTS set bits of a vector as one-hot selects, in ascending order.
module quadrilatero_grant_compactor
  import quadrilatero_pkg::*;
#(
  parameter int unsigned VEC_W   = quadrilatero_pkg::WIDTH,
  parameter int unsigned PORTS_N = quadrilatero_pkg::NUM_PORTS
) (
  input  logic [VEC_W-1:0]              vec_i,
  output logic [PORTS_N-1:0][VEC_W-1:0] sel_o,
  output logic                          overflow_o
);

  logic [VEC_W-1:0] rem_s;

  // Peel off the lowest remaining set bit once per port; anything left over is excess.
  always_comb begin
    rem_s = vec_i;
    sel_o = '0;
    for (int p = 0; p < PORTS_N; p++) begin
      sel_o[p] = rem_s & (~rem_s + VEC_W'(1'b1));
      rem_s    = rem_s & ~sel_o[p];
    end
    overflow_o = |rem_s;
  end

endmodule

// File: rtl/quadrilatero_row_dispatch.sv
// Per-slot multi-row operation tracking, arbiter request generation and grant-to-port compaction.
module quadrilatero_row_dispatch
  import quadrilatero_pkg::*;
#(
  parameter int unsigned WIDTH     = quadrilatero_pkg::WIDTH,
  parameter int unsigned NUM_PORTS = quadrilatero_pkg::NUM_PORTS,
  parameter int unsigned N_ROWS    = quadrilatero_pkg::N_ROWS,
  parameter int unsigned RADDR_W   = quadrilatero_pkg::RADDR_W
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [WIDTH-1:0]                     start_i,
  input  logic [WIDTH*RADDR_W-1:0]             reg_idx_i,
  output logic [WIDTH-1:0]                     req_o,
  input  logic [WIDTH-1:0]                     grant_i,
  output logic [NUM_PORTS-1:0]                 port_valid_o,
  output logic [NUM_PORTS*RADDR_W-1:0]         port_reg_o,
  output logic [NUM_PORTS*$clog2(N_ROWS)-1:0]  port_row_o,
  output logic [NUM_PORTS*$clog2(WIDTH)-1:0]   port_src_o,
  output logic [WIDTH-1:0]                     row_done_o,
  output logic                                 err_o
);

  localparam int unsigned RW = $clog2(N_ROWS);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

  logic [WIDTH-1:0]   busy_r;
  logic [RW-1:0]      row_r [WIDTH];
  logic [RADDR_W-1:0] reg_r [WIDTH];
  rf_port_req_t       port_r [NUM_PORTS];
  logic [WIDTH-1:0]   row_done_r;
  logic               err_r;

  logic [WIDTH-1:0]   busy_s;
  logic [RW-1:0]      row_s [WIDTH];
  logic [RADDR_W-1:0] reg_s [WIDTH];
  rf_port_req_t       port_s [NUM_PORTS];
  logic [WIDTH-1:0]   done_s;
  logic               err_s;

  logic [WIDTH-1:0]                 valid_grant_s;
  logic [WIDTH-1:0]                 bad_grant_s;
  logic [WIDTH-1:0]                 served_s;
  logic [NUM_PORTS-1:0][WIDTH-1:0]  sel_s;
  logic                             overflow_s;

  // A grant coinciding with a start is dropped silently; one to an idle slot is a protocol error.
  assign valid_grant_s = grant_i & busy_r & ~start_i;
  assign bad_grant_s   = grant_i & ~busy_r & ~start_i;

  quadrilatero_grant_compactor #(
    .VEC_W   (WIDTH),
    .PORTS_N (NUM_PORTS)
  ) u_compactor (
    .vec_i      (valid_grant_s),
    .sel_o      (sel_s),
    .overflow_o (overflow_s)
  );

  // Gather the selected slot's register, row and index onto each port.
  always_comb begin
    served_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_s[p]       = '0;
      port_s[p].valid = |sel_s[p];
      served_s        = served_s | sel_s[p];
      for (int s = 0; s < WIDTH; s++) begin
        port_s[p].reg_idx = port_s[p].reg_idx | (sel_s[p][s] ? reg_r[s] : {RADDR_W{1'b0}});
        port_s[p].row     = port_s[p].row     | (sel_s[p][s] ? row_r[s] : {RW{1'b0}});
        port_s[p].src     = port_s[p].src     | (sel_s[p][s] ? SW'(s)   : {SW{1'b0}});
      end
    end
  end

  // Next slot state: start restarts unconditionally, a served slot advances one row.
  always_comb begin
    busy_s = busy_r;
    done_s = '0;
    err_s  = err_r | (|bad_grant_s) | overflow_s;
    for (int s = 0; s < WIDTH; s++) begin
      row_s[s] = row_r[s];
      reg_s[s] = reg_r[s];
      if (start_i[s]) begin
        busy_s[s] = 1'b1;
        row_s[s]  = {RW{1'b0}};
        reg_s[s]  = reg_idx_i[s*RADDR_W +: RADDR_W];
      end else if (served_s[s]) begin
        row_s[s]  = row_r[s] + RW'(1'b1);
        busy_s[s] = (row_r[s] != LAST_ROW);
        done_s[s] = (row_r[s] == LAST_ROW);
      end else begin
        busy_s[s] = busy_r[s];
      end
    end
  end

  // State and output register stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_r     <= '0;
      row_done_r <= '0;
      err_r      <= 1'b0;
      for (int s = 0; s < WIDTH; s++) begin
        row_r[s] <= {RW{1'b0}};
        reg_r[s] <= {RADDR_W{1'b0}};
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_r[p] <= '0;
      end
    end else begin
      busy_r     <= busy_s;
      row_done_r <= done_s;
      err_r      <= err_s;
      for (int s = 0; s < WIDTH; s++) begin
        row_r[s] <= row_s[s];
        reg_r[s] <= reg_s[s];
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        port_r[p] <= port_s[p];
      end
    end
  end

  assign req_o      = busy_r;
  assign row_done_o = row_done_r;
  assign err_o      = err_r;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_valid_o[p]                = port_r[p].valid;
    assign port_reg_o[p*RADDR_W +: RADDR_W] = port_r[p].reg_idx;
    assign port_row_o[p*RW +: RW]           = port_r[p].row;
    assign port_src_o[p*SW +: SW]           = port_r[p].src;
  end

endmodule
